// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-format encoding for the decode-stage
// immediate generator.
package imm_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational RV32I immediate decoder: extracts and sign-extends the
// immediate to XLEN and classifies the opcode.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0] opcode;
  assign opcode = instr[6:0];

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: begin
        imm = XLEN'($signed(instr[31:20]));
        fmt = FMT_I;
      end
      OP_STORE: begin
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        fmt = FMT_S;
      end
      OP_BRANCH: begin
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm = XLEN'($signed({instr[31:12], 12'b0}));
        fmt = FMT_U;
      end
      OP_JAL: begin
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        fmt = FMT_J;
      end
      OP_REG: ;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a valid/ready handshake and a one-entry
// skid register behind the output stage, so in_ready never depends on out_ready.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output fmt_e             out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(
    .XLEN(XLEN)
  ) u_decode (
    .instr  (in_instr),
    .imm    (dec_imm),
    .fmt    (dec_fmt),
    .illegal(dec_illegal)
  );

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  fmt_e             out_fmt_q, out_fmt_d;
  logic             out_ill_q, out_ill_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  fmt_e             skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic accept;
  logic load_out;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign load_out = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;

    if (load_out) begin
      // A full skid blocks new input, so it is always the older entry here.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_ill_d    = skid_ill_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_ill_d   = dec_illegal;
        out_tag_d   = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_illegal;
      skid_tag_d   = in_tag;
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_ill_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_imm_q <= skid_imm_d;
    skid_fmt_q <= skid_fmt_d;
    skid_ill_q <= skid_ill_d;
    skid_tag_q <= skid_tag_d;
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. It covers all RV32I immediate formats (I, S, B, U, J), extends the result to XLEN, and flags unsupported opcodes. It has a valid/ready handshake with a 2-entry skid buffer, so back-pressure from execute never drops or duplicates an instruction. It sits between the fetch/decode register and the execute-stage operand mux. A TAG field (typically the PC) passes through alongside each instruction.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64; sign extension fills to XLEN.
TAG_W, 32, width of the pass-through tag (PC or ROB id).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
flush  input  1  discard all held entries (branch mispredict / trap)
in_valid  input  1  instruction present on in_instr
in_ready  output  1  block can accept this cycle
in_instr  input  32  raw instruction word
in_tag  input  TAG_W  pass-through tag
out_valid  output  1  out_* fields valid
out_ready  input  1  consumer accepts this cycle
out_imm  output  XLEN  extended immediate
out_fmt  output  3  immediate format code (package enum)
out_illegal  output  1  opcode not in the supported set
out_tag  output  TAG_W  tag aligned with out_imm

Behaviour:
- Reset (rst=1 at the clock edge): out_valid=0, skid empty, in_ready=1, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, out_tag=0.
- Opcode is instr[6:0]; decode is combinational, and the result is registered.
- I format (0010011, 0000011, 1100111, 0001111, 1110011): sext(instr[31:20]).
- S format (0100011): sext({instr[31:25], instr[11:7]}).
- B format (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U format (0110111, 0010111): sext({instr[31:12], 12'b0}); with XLEN=64, bit 31 fills [63:32].
- J format (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- R format (0110011): imm=0, fmt=FMT_NONE, illegal=0.
- Any other opcode: imm=0, fmt=FMT_NONE, illegal=1. The entry still flows through and is not dropped.
- Latency: 1 cycle from an accepted input (in_valid & in_ready) to out_valid, when the output stage is free.
- Handshake: an input transfers when in_valid & in_ready. An output transfers when out_valid & out_ready. Once out_valid is 1, out_* are held stable until the transfer completes.
- in_ready = !skid_valid. This is registered, with no combinational path from out_ready.
- Skid rules:
  - If the output stage is empty, or out_ready=1, a new accepted entry goes to the output stage.
  - If the output stage is full, out_ready=0, and an input is accepted, the entry goes to the skid register.
  - When the output transfers while the skid is full, the skid entry moves to the output stage the next cycle, and in_ready returns to 1.
- Ordering is strictly FIFO.
- Simultaneous accept and output transfer with the skid empty: the new entry replaces the output stage; out_valid stays 1.
- Flush: clears out_valid and skid_valid at the edge. An input presented in the flush cycle is dropped. in_ready=1 the next cycle. rst takes priority over flush.
- Reset mid-operation: both entries are discarded with no output transfer.
- Data registers need no reset beyond the values listed above.

Decomposition:
- Shared package imm_pkg:
  - opcode localparams: OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG.
  - 3-bit fmt enum: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
- One combinational sub-module, imm_decode_comb (instr → imm, fmt, illegal; parametrised by XLEN). It is instantiated once, feeding the skid/output registers in imm_gen_pipe.

Test Plan:
- addi 0xFFF00093, out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt=FMT_I, illegal=0. With XLEN=64 → 0xFFFFFFFFFFFFFFFF.
- Four-beat stream: sw 0xFE112E23 (−4), beq 0xFE000CE3 (−8), lui 0x123450B7, jal 0x0010006F, with out_ready=1 → outputs in order:
  - 0xFFFFFFFC (FMT_S)
  - 0xFFFFFFF8 (FMT_B)
  - 0x12345000 (FMT_U)
  - 0x00000800 (FMT_J)
- Back-pressure: out_ready=0 for 3 cycles while sending tags 1, 2, 3 →
  - tag 1 held on output, tag 2 in skid, in_ready=0, tag 3 not accepted.
  - Releasing out_ready yields tags 1, 2, 3 in order, with none lost or duplicated.
- Illegal opcode: instr 0x0000007F → out_imm=0, fmt=FMT_NONE, illegal=1. R-type 0x002081B3 → illegal=0, imm=0.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1; none of the three entries ever appears on the output.
- rst asserted mid-stream with out_ready=0 → next cycle out_valid=0, in_ready=1, out_imm=0; the first post-reset input has 1-cycle latency.
